// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the memory arbiter slice: default sizes for the
// 32x8 single-port memory, the arbiter FSM state type and a helper that
// sizes requester-index fields.
// No ports (package).
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int NREQ_DEF   = 2;
  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RDWAIT
  } arb_state_t;

  // A single requester still needs a 1-bit index field, so clamp at 1.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Requester-side bus of the memory arbiter. All requesters share one
// interface instance; their per-requester fields are packed side by side.
//   req     NREQ         per-requester request, held until ack
//   we      NREQ         per-requester 1=write, 0=read
//   addr    NREQ*ADDR_W  requester i at [i*ADDR_W +: ADDR_W]
//   wdata   NREQ*DATA_W  requester i at [i*DATA_W +: DATA_W]
//   ack     NREQ         one-cycle completion pulse
//   rdata   DATA_W       read data, valid while ack is high after a read
//   gnt_id  IDX_W        current/last granted requester
//   busy    1            arbiter not idle
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int NREQ   = NREQ_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  localparam int IDX_W = idxWidth(NREQ);

  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        we;
  logic [NREQ*ADDR_W-1:0] addr;
  logic [NREQ*DATA_W-1:0] wdata;
  logic [NREQ-1:0]        ack;
  logic [DATA_W-1:0]      rdata;
  logic [IDX_W-1:0]       gnt_id;
  logic                   busy;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata, gnt_id, busy
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata, gnt_id, busy
  );

endinterface

// File: rtl/mem_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker. Scans requesters starting one past the
// last winner, wrapping modulo NREQ, and reports the first one requesting.
//   i_req     NREQ   request vector
//   i_last    IDX_W  index of the previous winner
//   o_winner  IDX_W  selected requester (0 when none)
//   o_valid   1      at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int IDX_W = idxWidth(NREQ)
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic [IDX_W-1:0] o_winner,
  output logic             o_valid
);

  // One extra bit so last+k cannot overflow before the modulo fold.
  logic [IDX_W:0] w_cand;

  // Walk the NREQ candidates in priority order; the previous winner is
  // visited last, which is what makes continuous contention alternate.
  always_comb begin
    o_winner = '0;
    o_valid  = 1'b0;
    w_cand   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = {1'b0, i_last} + (IDX_W + 1)'(k);
      if (w_cand >= (IDX_W + 1)'(NREQ)) begin
        w_cand = w_cand - (IDX_W + 1)'(NREQ);
      end
      if (!o_valid && i_req[w_cand[IDX_W-1:0]]) begin
        o_valid  = 1'b1;
        o_winner = w_cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Round-robin arbiter/sequencer sharing one single-port 32x8 memory among
// NREQ requesters. One request is latched per IDLE pass; writes complete in
// the ACCESS cycle, reads wait one cycle in RDWAIT for the registered
// memory output.
//   clk          in   system clock, posedge
//   rst          in   asynchronous active-high reset
//   bus          if   requester bus (slave modport of mem_arbiter_if)
//   o_mem_read   out  memory read strobe
//   o_mem_write  out  memory write strobe
//   o_mem_addr   out  memory address (holds while idle)
//   o_mem_din    out  memory write data (holds while idle)
//   i_mem_dout   in   memory read data, valid one cycle after read strobe
// ---------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ   = NREQ_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  mem_arbiter_if.slave      bus,
  output logic              o_mem_read,
  output logic              o_mem_write,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_din,
  input  logic [DATA_W-1:0] i_mem_dout
);

  localparam int IDX_W = idxWidth(NREQ);

  arb_state_t        r_state;
  arb_state_t        w_nextState;
  logic [IDX_W-1:0]  w_winner;
  logic              w_valid;
  logic [IDX_W-1:0]  r_last;
  logic [IDX_W-1:0]  r_gnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [NREQ-1:0]   w_ack;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .i_req    (bus.req),
    .i_last   (r_last),
    .o_winner (w_winner),
    .o_valid  (w_valid)
  );

  // State register; reset drops any in-flight transaction without an ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state: writes return straight to IDLE, reads take one extra cycle
  // for the registered memory output.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_valid) w_nextState = ACCESS;
      ACCESS:  w_nextState = r_we ? IDLE : RDWAIT;
      RDWAIT:  w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Output decode: strobes are only ever raised in ACCESS, so they are
  // one cycle wide and mutually exclusive; ack goes to the latched grantee.
  always_comb begin
    w_ack       = '0;
    o_mem_read  = 1'b0;
    o_mem_write = 1'b0;
    case (r_state)
      ACCESS: begin
        if (r_we) begin
          o_mem_write  = 1'b1;
          w_ack[r_gnt] = 1'b1;
        end else begin
          o_mem_read = 1'b1;
        end
      end
      RDWAIT:  w_ack[r_gnt] = 1'b1;
      default: ;
    endcase
  end

  // Request latch, round-robin pointer and read-data register. Requests are
  // only looked at in IDLE, so later changes on the bus are ignored. Write
  // data is only captured for writes so mem_din keeps the last written value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last  <= IDX_W'(NREQ - 1);
      r_gnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (r_state == IDLE && w_valid) begin
        r_gnt  <= w_winner;
        r_last <= w_winner;
        r_we   <= bus.we[w_winner];
        r_addr <= bus.addr[w_winner*ADDR_W +: ADDR_W];
        if (bus.we[w_winner]) begin
          r_wdata <= bus.wdata[w_winner*DATA_W +: DATA_W];
        end
      end
      if (r_state == RDWAIT) begin
        r_rdata <= i_mem_dout;
      end
    end
  end

  // During RDWAIT the memory output is passed through so rdata is valid in
  // the same cycle as ack; afterwards the captured copy holds it.
  assign bus.rdata  = (r_state == RDWAIT) ? i_mem_dout : r_rdata;
  assign bus.ack    = w_ack;
  assign bus.gnt_id = r_gnt;
  assign bus.busy   = (r_state != IDLE);
  assign o_mem_addr = r_addr;
  assign o_mem_din  = r_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Scoreboard bench for mem_arbiter with a behavioural memory and a
// transaction-level round-robin reference model.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int NREQ   = 2;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int MAXOPS = 80;

  typedef struct {
    bit                isWrite;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } op_t;

  typedef struct {
    int                id;
    bit                isWrite;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              memRead;
  logic              memWrite;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memDin;
  logic [DATA_W-1:0] memDout = '0;
  logic [DATA_W-1:0] mem    [32];
  logic [DATA_W-1:0] refMem [32];

  op_t  stim [NREQ][MAXOPS];
  int   stimCnt [NREQ];
  int   modelLast;
  exp_t ackQ[$];
  exp_t strobeQ[$];
  exp_t monE;
  exp_t monS;
  int   nTotal = 0;
  int   nBad   = 0;

  mem_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_mem_read  (memRead),
    .o_mem_write (memWrite),
    .o_mem_addr  (memAddr),
    .o_mem_din   (memDin),
    .i_mem_dout  (memDout)
  );

  always #5 clk = ~clk;

  // Single-port memory with registered read data.
  always @(posedge clk) begin
    if (memWrite) mem[memAddr] <= memDin;
    if (memRead)  memDout <= mem[memAddr];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTotal++;
    if (act !== exp) begin
      nBad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic addOp(input int id, input bit isWrite, input int addr, input int data);
    stim[id][stimCnt[id]].isWrite = isWrite;
    stim[id][stimCnt[id]].addr    = ADDR_W'(addr);
    stim[id][stimCnt[id]].data    = DATA_W'(data);
    stimCnt[id]++;
  endtask

  // Monitor: every strobe and every ack is matched against the head of the
  // corresponding expectation queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (memRead || memWrite) begin
        if (strobeQ.size() == 0) begin
          checkOutput("unexpected strobe", {30'd0, memRead, memWrite}, 32'd0);
        end else begin
          monS = strobeQ.pop_front();
          checkOutput("mem_write", {31'd0, memWrite}, {31'd0, monS.isWrite});
          checkOutput("mem_read", {31'd0, memRead}, {31'd0, !monS.isWrite});
          checkOutput("mem_addr", 32'(memAddr), 32'(monS.addr));
          if (monS.isWrite) checkOutput("mem_din", 32'(memDin), 32'(monS.data));
        end
      end
      if (bus.ack != '0) begin
        if (ackQ.size() == 0) begin
          checkOutput("unexpected ack", 32'(bus.ack), 32'd0);
        end else begin
          monE = ackQ.pop_front();
          checkOutput("ack vector", 32'(bus.ack), 32'(1 << monE.id));
          checkOutput("gnt_id", 32'(bus.gnt_id), 32'(monE.id));
          if (!monE.isWrite) checkOutput("rdata", 32'(bus.rdata), 32'(monE.data));
        end
      end
    end
  end

  // Runs the queued per-requester operations. The reference model first
  // decides the service order (each pass picks the next requester after the
  // previous winner that still has work) and the resulting memory contents,
  // then the driver plays the requesters cycle by cycle.
  task automatic applyStimulus();
    int   pos   [NREQ];
    int   done  [NREQ];
    int   lat   [NREQ];
    bit   active[NREQ];
    int   total;
    int   doneSum;
    int   cycles;
    int   id;
    bit   single;
    op_t  o;
    exp_t e;

    total = 0;
    for (int i = 0; i < NREQ; i++) begin
      pos[i] = 0; done[i] = 0; lat[i] = 0; active[i] = 1'b0;
      total += stimCnt[i];
    end
    single = (stimCnt[0] == 0) || (stimCnt[1] == 0);

    for (int n = 0; n < total; n++) begin
      id = -1;
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (modelLast + k) % NREQ;
        if (id < 0 && pos[c] < stimCnt[c]) id = c;
      end
      o = stim[id][pos[id]];
      pos[id]++;
      modelLast = id;
      e.id = id; e.isWrite = o.isWrite; e.addr = o.addr;
      if (o.isWrite) begin
        refMem[o.addr] = o.data;
        e.data = o.data;
      end else begin
        e.data = refMem[o.addr];
      end
      ackQ.push_back(e);
      strobeQ.push_back(e);
    end

    cycles  = 0;
    doneSum = 0;
    while (doneSum < total && cycles < 3000) begin
      @(negedge clk);
      cycles++;
      for (int i = 0; i < NREQ; i++) begin
        if (active[i]) begin
          lat[i]++;
          if (bus.ack[i]) begin
            if (single) begin
              checkOutput("ack latency", 32'(lat[i]), stim[i][done[i]].isWrite ? 32'd1 : 32'd2);
            end
            bus.req[i] = 1'b0;
            active[i]  = 1'b0;
            done[i]++;
            doneSum++;
          end
        end else if (done[i] < stimCnt[i]) begin
          o = stim[i][done[i]];
          bus.req[i]                     = 1'b1;
          bus.we[i]                      = o.isWrite;
          bus.addr[i*ADDR_W +: ADDR_W]   = o.addr;
          bus.wdata[i*DATA_W +: DATA_W]  = o.data;
          active[i] = 1'b1;
          lat[i]    = 0;
        end
      end
    end
    checkOutput("batch complete", 32'(doneSum), 32'(total));
    for (int i = 0; i < NREQ; i++) stimCnt[i] = 0;
    bus.req = '0;
    @(negedge clk);
  endtask

  initial begin
    bus.req   = '0;
    bus.we    = '0;
    bus.addr  = '0;
    bus.wdata = '0;
    for (int i = 0; i < 32; i++) begin
      mem[i]    = '0;
      refMem[i] = '0;
    end
    for (int i = 0; i < NREQ; i++) stimCnt[i] = 0;
    modelLast = NREQ - 1;

    // Reset state
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset ack", 32'(bus.ack), 32'd0);
    checkOutput("reset mem_read", {31'd0, memRead}, 32'd0);
    checkOutput("reset mem_write", {31'd0, memWrite}, 32'd0);
    checkOutput("reset busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("reset rdata", 32'(bus.rdata), 32'd0);
    checkOutput("reset gnt_id", 32'(bus.gnt_id), 32'd0);
    checkOutput("reset mem_addr", 32'(memAddr), 32'd0);
    checkOutput("reset mem_din", 32'(memDin), 32'd0);
    rst = 1'b0;

    // Contention right after reset: requester 0 first, then strict alternation
    addOp(0, 1, 10, 8'h3C); addOp(0, 1, 11, 8'hC3); addOp(0, 0, 10, 0);
    addOp(1, 1, 20, 8'h5A); addOp(1, 0, 20, 0);     addOp(1, 0, 11, 0);
    applyStimulus();

    // Write then read back through requester 0
    addOp(0, 1, 5, 8'hA5); addOp(0, 0, 5, 0);
    applyStimulus();

    // Reset while a read of address 3 sits in RDWAIT
    monE.id = 0; monE.isWrite = 1'b0; monE.addr = 5'd3; monE.data = '0;
    strobeQ.push_back(monE);
    bus.we[0] = 1'b0;
    bus.addr[0 +: ADDR_W] = 5'd3;
    bus.req[0] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("rdwait busy", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    #1;
    bus.req = '0;
    checkOutput("midreset ack", 32'(bus.ack), 32'd0);
    @(negedge clk);
    checkOutput("midreset mem_read", {31'd0, memRead}, 32'd0);
    checkOutput("midreset busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    checkOutput("midreset ack held", 32'(bus.ack), 32'd0);
    rst = 1'b0;
    modelLast = NREQ - 1;
    checkOutput("midreset strobe consumed", 32'(strobeQ.size()), 32'd0);

    // Requester 1 alone after reset
    addOp(1, 1, 7, 8'h77); addOp(1, 0, 7, 0);
    applyStimulus();

    // Sweep via requester 1: data = address, then read everything back
    for (int a = 0; a < 32; a++) addOp(1, 1, a, a);
    for (int a = 0; a < 32; a++) addOp(1, 0, a, 0);
    applyStimulus();

    // Requester 0 clears memory while requester 1 reads concurrently
    for (int a = 0; a < 32; a++) addOp(0, 1, a, 8'h00);
    for (int a = 0; a < 32; a++) addOp(1, 0, a, 0);
    applyStimulus();
    for (int a = 0; a < 32; a++) addOp(1, 0, a, 0);
    applyStimulus();

    // Randomised mixed traffic
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < NREQ; i++) begin
        int n;
        n = int'($urandom_range(0, 6));
        for (int j = 0; j < n; j++) begin
          addOp(i, bit'($urandom_range(0, 1)), int'($urandom_range(0, 31)), int'($urandom_range(0, 255)));
        end
      end
      applyStimulus();
    end

    repeat (3) @(negedge clk);
    checkOutput("ack queue drained", 32'(ackQ.size()), 32'd0);
    checkOutput("strobe queue drained", 32'(strobeQ.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", nTotal, nBad);
    $finish;
  end

endmodule
